executor_alu_pipe: RTL and testbench

- Parametrised, pipelined successor to the execution-stage ALU.
- Accepts one ALU operation per cycle under valid/ready handshake and returns a result with correct N/Z/C/V.
  - C is ARM-style: carry out for adds, NOT-borrow for subtracts, shifter carry passed through for logical ops.
  - V is true signed overflow.
- Adds configurable datapath width, 1- or 2-stage latency, downstream backpressure and a pipeline flush for branch/exception redirect.

---
 rtl/alu_pkg.sv | 48 ++++
 rtl/alu_core.sv | 72 +++++++
 rtl/executor_alu_pipe.sv | 149 ++++++++++++++
 tb/tb_executor_alu_pipe.sv | 429 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the execution-stage ALU pipeline.
// Contents:
//   - opcode encodings (OP_OP1 .. OP_SBC); 7, E and F are undefined
//   - flags_t: the {n, z, c, v} condition-flag bundle
//   - decode helpers: is_arith, is_sub, is_reverse, is_illegal
package alu_pkg;

  localparam logic [3:0] OP_OP1 = 4'h0;
  localparam logic [3:0] OP_OP2 = 4'h1;
  localparam logic [3:0] OP_AND = 4'h2;
  localparam logic [3:0] OP_ORR = 4'h3;
  localparam logic [3:0] OP_EOR = 4'h4;
  localparam logic [3:0] OP_BIC = 4'h5;
  localparam logic [3:0] OP_MVN = 4'h6;
  localparam logic [3:0] OP_ADD = 4'h8;
  localparam logic [3:0] OP_ADC = 4'h9;
  localparam logic [3:0] OP_RSB = 4'hA;
  localparam logic [3:0] OP_RSC = 4'hB;
  localparam logic [3:0] OP_SUB = 4'hC;
  localparam logic [3:0] OP_SBC = 4'hD;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } flags_t;

  function automatic logic is_illegal(logic [3:0] op);
    return (op == 4'h7) || (op == 4'hE) || (op == 4'hF);
  endfunction

  // 8..D use the adder
  function automatic logic is_arith(logic [3:0] op);
    return op[3] & ~(op[2] & op[1]);
  endfunction

  // RSB, RSC, SUB, SBC invert the second adder input
  function automatic logic is_sub(logic [3:0] op);
    return op[3] & (op[2] ^ op[1]);
  endfunction

  // RSB, RSC swap operands before the adder
  function automatic logic is_reverse(logic [3:0] op);
    return op[3:1] == 3'b101;
  endfunction

endpackage

// File: rtl/alu_core.sv
// Combinational ALU, split into two halves so the pipeline can cut it at the
// adder output.
//   Front half: opcode/op1/op2/c_in -> add_sum (WIDTH+1 bits), add_ovf,
//               logic_res (result of the logical opcodes).
//   Back half:  sel_* (front-half values, possibly registered) -> result,
//               flags {n,z,c,v}, illegal.
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [3:0]       opcode,
  input  logic [WIDTH-1:0] op1,
  input  logic [WIDTH-1:0] op2,
  input  logic             c_in,
  output logic [WIDTH:0]   add_sum,
  output logic             add_ovf,
  output logic [WIDTH-1:0] logic_res,
  input  logic [3:0]       sel_opcode,
  input  logic [WIDTH:0]   sel_sum,
  input  logic             sel_ovf,
  input  logic [WIDTH-1:0] sel_logic,
  input  logic             sel_c_in,
  input  logic             sel_v_in,
  output logic [WIDTH-1:0] result,
  output flags_t           flags,
  output logic             illegal
);

  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] b_eff;
  logic             cin;

  // One adder for everything: a + b' + cin. Subtracts invert b and carry in
  // 1 (or c_in for the with-carry forms), so bit WIDTH is ARM's NOT-borrow.
  always_comb begin
    a       = is_reverse(opcode) ? op2 : op1;
    b       = is_reverse(opcode) ? op1 : op2;
    b_eff   = is_sub(opcode) ? ~b : b;
    cin     = opcode[0] ? c_in : is_sub(opcode);
    add_sum = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, cin};
    add_ovf = (a[WIDTH-1] == b_eff[WIDTH-1]) & (add_sum[WIDTH-1] != a[WIDTH-1]);
  end

  always_comb begin
    logic_res = '0;
    case (opcode)
      OP_OP1:  logic_res = op1;
      OP_OP2:  logic_res = op2;
      OP_AND:  logic_res = op1 & op2;
      OP_ORR:  logic_res = op1 | op2;
      OP_EOR:  logic_res = op1 ^ op2;
      OP_BIC:  logic_res = op1 & ~op2;
      OP_MVN:  logic_res = ~op2;
      default: logic_res = '0;
    endcase
  end

  // Logical and undefined opcodes pass the incoming C and V through.
  always_comb begin
    illegal = is_illegal(sel_opcode);
    if (illegal)                  result = '0;
    else if (is_arith(sel_opcode)) result = sel_sum[WIDTH-1:0];
    else                          result = sel_logic;
    flags.c = is_arith(sel_opcode) ? sel_sum[WIDTH] : sel_c_in;
    flags.v = is_arith(sel_opcode) ? sel_ovf : sel_v_in;
    flags.n = result[WIDTH-1];
    flags.z = (result == '0);
  end

endmodule

// File: rtl/executor_alu_pipe.sv
// Pipelined execution-stage ALU with valid/ready handshake and flush.
// Ports:
//   clk, rst (sync, active-high), flush (kill all in-flight ops)
//   in_valid/in_ready, opcode, op1, op2, c_in, v_in : operation input
//   out_valid/out_ready, result, n/z/c/v_flag, illegal : result output
// STAGES=1: result registered one cycle after acceptance.
// STAGES=2: adder sum and logic result registered first, flags/selection in
//           the output register one cycle later.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. A stage may load when it is empty or its content moves on in
// the same edge. in_ready is combinational from out_ready (no skid buffer)
// and is forced low while flush is high.
module executor_alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       opcode,
  input  logic [WIDTH-1:0] op1,
  input  logic [WIDTH-1:0] op2,
  input  logic             c_in,
  input  logic             v_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             n_flag,
  output logic             z_flag,
  output logic             c_flag,
  output logic             v_flag,
  output logic             illegal
);

  logic             out_adv;     // output register may load this edge
  logic             feed_valid;  // op presented to the output register
  logic [WIDTH:0]   add_sum;
  logic             add_ovf;
  logic [WIDTH-1:0] logic_res;
  logic [3:0]       sel_opcode;
  logic [WIDTH:0]   sel_sum;
  logic             sel_ovf;
  logic [WIDTH-1:0] sel_logic;
  logic             sel_c_in;
  logic             sel_v_in;
  logic [WIDTH-1:0] fin_result;
  flags_t           fin_flags;
  logic             fin_illegal;
  flags_t           out_flags;

  assign out_adv = ~out_valid | out_ready;

  alu_core #(.WIDTH(WIDTH)) u_core (
    .opcode     (opcode),
    .op1        (op1),
    .op2        (op2),
    .c_in       (c_in),
    .add_sum    (add_sum),
    .add_ovf    (add_ovf),
    .logic_res  (logic_res),
    .sel_opcode (sel_opcode),
    .sel_sum    (sel_sum),
    .sel_ovf    (sel_ovf),
    .sel_logic  (sel_logic),
    .sel_c_in   (sel_c_in),
    .sel_v_in   (sel_v_in),
    .result     (fin_result),
    .flags      (fin_flags),
    .illegal    (fin_illegal)
  );

  if (STAGES == 2) begin : g_two
    logic             s1_valid;
    logic [3:0]       s1_opcode;
    logic [WIDTH:0]   s1_sum;
    logic             s1_ovf;
    logic [WIDTH-1:0] s1_logic;
    logic             s1_c_in;
    logic             s1_v_in;

    assign in_ready   = ~flush & (~s1_valid | out_adv);
    assign feed_valid = s1_valid;

    always_ff @(posedge clk) begin
      if (rst || flush)             s1_valid <= 1'b0;
      else if (~s1_valid | out_adv) s1_valid <= in_valid;
    end

    // Payload is don't-care while s1_valid is low, so no reset here.
    always_ff @(posedge clk) begin
      if (in_valid & in_ready) begin
        s1_opcode <= opcode;
        s1_sum    <= add_sum;
        s1_ovf    <= add_ovf;
        s1_logic  <= logic_res;
        s1_c_in   <= c_in;
        s1_v_in   <= v_in;
      end
    end

    assign sel_opcode = s1_opcode;
    assign sel_sum    = s1_sum;
    assign sel_ovf    = s1_ovf;
    assign sel_logic  = s1_logic;
    assign sel_c_in   = s1_c_in;
    assign sel_v_in   = s1_v_in;
  end else begin : g_one
    assign in_ready   = ~flush & out_adv;
    assign feed_valid = in_valid;
    assign sel_opcode = opcode;
    assign sel_sum    = add_sum;
    assign sel_ovf    = add_ovf;
    assign sel_logic  = logic_res;
    assign sel_c_in   = c_in;
    assign sel_v_in   = v_in;
  end

  // Output register: payload is reset so outputs read 0 until the first
  // result; afterwards it only reloads when a valid op moves in, which keeps
  // it stable under backpressure.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      result    <= '0;
      out_flags <= '0;
      illegal   <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (out_adv) begin
      out_valid <= feed_valid;
      if (feed_valid) begin
        result    <= fin_result;
        out_flags <= fin_flags;
        illegal   <= fin_illegal;
      end
    end
  end

  assign n_flag = out_flags.n;
  assign z_flag = out_flags.z;
  assign c_flag = out_flags.c;
  assign v_flag = out_flags.v;

endmodule

// File: tb/tb_executor_alu_pipe.sv
// Bench for executor_alu_pipe. Three instances share clk/rst:
//   dut 0: WIDTH=32 STAGES=1, dut 1: WIDTH=32 STAGES=2, dut 2: WIDTH=8 STAGES=1
// Expected results are 69-bit vectors {illegal, n, z, c, v, result[63:0]}.
module tb_executor_alu_pipe;
  import alu_pkg::*;

  logic              clk = 1'b0;
  logic              rst;
  logic [2:0]        flush, in_valid, in_ready, c_in, v_in;
  logic [2:0]        out_valid, out_ready, n_flag, z_flag, c_flag, v_flag, illegal;
  logic [3:0]        opcode [3];
  logic [63:0]       op1 [3];
  logic [63:0]       op2 [3];
  logic [2:0][63:0]  result;

  int n_checks = 0;
  int n_fail   = 0;
  int n_out [3];

  logic [68:0] exp_q0[$];
  logic [68:0] exp_q1[$];
  logic [68:0] exp_q2[$];

  typedef struct {
    int          dut;
    logic [3:0]  op;
    logic [63:0] a;
    logic [63:0] b;
    logic        ci;
    logic        vi;
    logic [68:0] exp;
  } vec_t;

  vec_t tbl [19];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  // ---------------- DUT instances ----------------
  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int W = (g == 2) ? 8 : 32;
    localparam int S = (g == 1) ? 2 : 1;
    logic [W-1:0] res_l;

    executor_alu_pipe #(.WIDTH(W), .STAGES(S)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush[g]),
      .in_valid  (in_valid[g]),
      .in_ready  (in_ready[g]),
      .opcode    (opcode[g]),
      .op1       (op1[g][W-1:0]),
      .op2       (op2[g][W-1:0]),
      .c_in      (c_in[g]),
      .v_in      (v_in[g]),
      .out_valid (out_valid[g]),
      .out_ready (out_ready[g]),
      .result    (res_l),
      .n_flag    (n_flag[g]),
      .z_flag    (z_flag[g]),
      .c_flag    (c_flag[g]),
      .v_flag    (v_flag[g]),
      .illegal   (illegal[g])
    );

    assign result[g] = 64'(res_l);
  end

  // ---------------- helpers ----------------
  function automatic void q_push(int d, logic [68:0] v);
    case (d)
      0:       exp_q0.push_back(v);
      1:       exp_q1.push_back(v);
      default: exp_q2.push_back(v);
    endcase
  endfunction

  function automatic int q_size(int d);
    case (d)
      0:       return exp_q0.size();
      1:       return exp_q1.size();
      default: return exp_q2.size();
    endcase
  endfunction

  function automatic logic [68:0] q_pop(int d);
    case (d)
      0:       return exp_q0.pop_front();
      1:       return exp_q1.pop_front();
      default: return exp_q2.pop_front();
    endcase
  endfunction

  function automatic logic [68:0] dut_vec(int d);
    return {illegal[d], n_flag[d], z_flag[d], c_flag[d], v_flag[d], result[d]};
  endfunction

  function automatic longint sext(logic [63:0] x, int w);
    if (x[w-1]) return longint'(x) - (longint'(1) << w);
    return longint'(x);
  endfunction

  // Reference model: carry from the true unsigned sum / unsigned compare,
  // overflow from the exact signed result falling outside the w-bit range.
  function automatic logic [68:0] model(int w, logic [3:0] op, logic [63:0] a_in,
                                        logic [63:0] b_in, logic ci, logic vi);
    logic [63:0] mask, a, b, x, y, r, full;
    logic        c, v, ill, bw, cadd;
    longint      ex, lo, hi;
    mask = (64'd1 << w) - 64'd1;
    a = a_in & mask;
    b = b_in & mask;
    lo = -(longint'(1) << (w - 1));
    hi = (longint'(1) << (w - 1)) - 1;
    c = ci; v = vi; ill = 1'b0; r = '0;
    case (op)
      4'h0: r = a;
      4'h1: r = b;
      4'h2: r = a & b;
      4'h3: r = a | b;
      4'h4: r = a ^ b;
      4'h5: r = a & ~b;
      4'h6: r = ~b;
      4'h8, 4'h9: begin
        cadd = (op == 4'h9) ? ci : 1'b0;
        full = a + b + 64'(cadd);
        r    = full;
        c    = full[w];
        ex   = sext(a, w) + sext(b, w) + longint'(cadd);
        v    = (ex < lo) || (ex > hi);
      end
      4'hA, 4'hB, 4'hC, 4'hD: begin
        x  = (op[3:1] == 3'b101) ? b : a;
        y  = (op[3:1] == 3'b101) ? a : b;
        bw = op[0] ? ~ci : 1'b0;
        r  = x - y - 64'(bw);
        c  = (x >= y + 64'(bw));
        ex = sext(x, w) - sext(y, w) - longint'(bw);
        v  = (ex < lo) || (ex > hi);
      end
      default: ill = 1'b1;
    endcase
    r = r & mask;
    return {ill, r[w-1], (r == 64'd0), c, v, r};
  endfunction

  function automatic vec_t mk(int dut, logic [3:0] op, logic [63:0] a, logic [63:0] b,
                              logic ci, logic vi, logic [63:0] res,
                              logic n, logic z, logic c, logic v, logic ill);
    vec_t t;
    t.dut = dut; t.op = op; t.a = a; t.b = b; t.ci = ci; t.vi = vi;
    t.exp = {ill, n, z, c, v, res};
    return t;
  endfunction

  task automatic chk_bit(string name, logic act, logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, required %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_vec(string name, logic [68:0] act, logic [68:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got {ill,n,z,c,v}=%b result=%h, required {ill,n,z,c,v}=%b result=%h (t=%0t)",
               name, act[68:64], act[63:0], exp[68:64], exp[63:0], $time);
    end
  endtask

  task automatic drive(int d, logic [3:0] op, logic [63:0] a, logic [63:0] b, logic ci, logic vi);
    in_valid[d] = 1'b1;
    opcode[d]   = op;
    op1[d]      = a;
    op2[d]      = b;
    c_in[d]     = ci;
    v_in[d]     = vi;
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (!rst) begin
      for (int d = 0; d < 3; d++) begin
        if (out_valid[d] && out_ready[d]) begin
          n_out[d]++;
          if (q_size(d) == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL dut%0d_unexpected_output: got result=%h, required no output (t=%0t)",
                     d, result[d], $time);
          end else begin
            chk_vec($sformatf("dut%0d_result", d), dut_vec(d), q_pop(d));
          end
        end
      end
    end
  end

  // ---------------- test sequences ----------------
  task automatic run_table();
    for (int i = 0; i < 19; i++) begin
      int d;
      d = tbl[i].dut;
      out_ready[d] = 1'b1;
      drive(d, tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].ci, tbl[i].vi);
      @(negedge clk);
      chk_bit($sformatf("tbl%0d_pre_accept_out_valid", i), out_valid[d], 1'b0);
      chk_bit($sformatf("tbl%0d_in_ready", i), in_ready[d], 1'b1);
      if (in_ready[d]) q_push(d, tbl[i].exp);
      @(posedge clk); #1;
      in_valid[d] = 1'b0;
      chk_bit($sformatf("tbl%0d_latency_out_valid", i), out_valid[d], 1'b1);
      @(posedge clk); #1;
    end
  endtask

  task automatic run_random(int d, int n, int w);
    int sent = 0;
    int cyc  = 0;
    logic [63:0] corner [5];
    logic [63:0] a, b;
    corner[0] = 64'd0;
    corner[1] = (64'd1 << w) - 64'd1;
    corner[2] = 64'd1 << (w - 1);
    corner[3] = (64'd1 << (w - 1)) - 64'd1;
    corner[4] = 64'd1;
    in_valid[d] = 1'b0;
    while ((sent < n || q_size(d) != 0) && cyc < 4000) begin
      logic acc;
      acc = 1'b0;
      if (!in_valid[d] && sent < n && $urandom_range(0, 3) != 0) begin
        a = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : {$urandom, $urandom};
        b = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : {$urandom, $urandom};
        drive(d, 4'($urandom_range(0, 15)), a, b, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end
      out_ready[d] = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      if (in_valid[d] && in_ready[d]) begin
        q_push(d, model(w, opcode[d], op1[d], op2[d], c_in[d], v_in[d]));
        sent++;
        acc = 1'b1;
      end
      @(posedge clk); #1;
      if (acc) in_valid[d] = 1'b0;
      cyc++;
    end
    n_checks++;
    if (cyc >= 4000) begin
      n_fail++;
      $display("FAIL dut%0d_random_timeout: got %0d ops sent, %0d pending, required all drained", d, sent, q_size(d));
    end
    in_valid[d] = 1'b0;
  endtask

  task automatic stream_test();
    int sent = 0;
    int cyc  = 0;
    int base;
    logic [63:0] a [8];
    logic [63:0] b [8];
    logic saw_block = 1'b0;
    logic held      = 1'b0;
    logic [68:0] held_vec = '0;
    base = n_out[1];
    for (int i = 0; i < 8; i++) begin
      a[i] = {32'd0, $urandom};
      b[i] = {32'd0, $urandom};
    end
    drive(1, OP_ADD, a[0], b[0], 1'b0, 1'b0);
    while ((sent < 8 || q_size(1) != 0) && cyc < 100) begin
      int   occ;
      logic exp_rdy;
      logic acc;
      acc = 1'b0;
      occ = q_size(1);
      out_ready[1] = !(cyc >= 3 && cyc <= 5);
      exp_rdy = !(occ == 2 && !out_ready[1]);
      @(negedge clk);
      if (sent < 8) chk_bit($sformatf("stream_in_ready_cyc%0d", cyc), in_ready[1], exp_rdy);
      if (!in_ready[1]) saw_block = 1'b1;
      if (held) chk_vec($sformatf("stream_hold_cyc%0d", cyc), dut_vec(1), held_vec);
      held     = out_valid[1] && !out_ready[1];
      held_vec = dut_vec(1);
      if (in_valid[1] && in_ready[1]) begin
        q_push(1, model(32, opcode[1], op1[1], op2[1], c_in[1], v_in[1]));
        sent++;
        acc = 1'b1;
      end
      @(posedge clk); #1;
      if (acc) begin
        if (sent < 8) drive(1, OP_ADD, a[sent], b[sent], 1'b0, 1'b0);
        else          in_valid[1] = 1'b0;
      end
      cyc++;
    end
    in_valid[1] = 1'b0;
    chk_bit("stream_in_ready_dropped", saw_block, 1'b1);
    n_checks++;
    if (n_out[1] - base != 8) begin
      n_fail++;
      $display("FAIL stream_count: got %0d results, required 8", n_out[1] - base);
    end
  endtask

  task automatic flush_test();
    out_ready[1] = 1'b0;
    drive(1, OP_ADD, 64'd1, 64'd2, 1'b0, 1'b0);
    @(negedge clk);
    chk_bit("flush_accept_a", in_ready[1], 1'b1);
    @(posedge clk); #1;
    drive(1, OP_SUB, 64'd9, 64'd4, 1'b0, 1'b0);
    @(negedge clk);
    chk_bit("flush_accept_b", in_ready[1], 1'b1);
    @(posedge clk); #1;
    drive(1, OP_ADD, 64'd7, 64'd7, 1'b0, 1'b0);
    flush[1] = 1'b1;
    @(negedge clk);
    chk_bit("flush_in_ready_low", in_ready[1], 1'b0);
    chk_bit("flush_out_valid_before", out_valid[1], 1'b1);
    @(posedge clk); #1;
    flush[1]     = 1'b0;
    in_valid[1]  = 1'b0;
    out_ready[1] = 1'b1;
    chk_bit("flush_out_valid_after", out_valid[1], 1'b0);
    repeat (4) @(posedge clk);
    #1;
    chk_bit("flush_out_valid_idle", out_valid[1], 1'b0);
    // the pipe must still work normally after a flush
    drive(1, OP_ADD, 64'd3, 64'd4, 1'b0, 1'b0);
    @(negedge clk);
    chk_bit("flush_recover_ready", in_ready[1], 1'b1);
    q_push(1, {5'b00000, 64'd7});
    @(posedge clk); #1;
    in_valid[1] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic reset_test();
    out_ready[2] = 1'b0;
    drive(2, OP_ADD, 64'h40, 64'h41, 1'b0, 1'b0);
    @(posedge clk); #1;
    drive(2, OP_ADD, 64'h11, 64'h22, 1'b0, 1'b0);
    chk_bit("rst_mid_pre_valid", out_valid[2], 1'b1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk_bit("rst_mid_out_valid", out_valid[2], 1'b0);
    chk_vec("rst_mid_outputs", dut_vec(2), 69'd0);
    rst = 1'b0;
    in_valid[2] = 1'b0;
    chk_bit("rst_mid_in_ready", in_ready[2], 1'b1);
    out_ready[2] = 1'b1;
    repeat (3) @(posedge clk);
    #1;
  endtask

  // ---------------- main ----------------
  initial begin
    rst       = 1'b1;
    flush     = '0;
    in_valid  = '0;
    c_in      = '0;
    v_in      = '0;
    out_ready = '0;
    for (int d = 0; d < 3; d++) begin
      opcode[d] = '0;
      op1[d]    = '0;
      op2[d]    = '0;
      n_out[d]  = 0;
    end

    tbl[0]  = mk(0, OP_ADD, 64'h7FFF_FFFF, 64'h1,         0, 0, 64'h8000_0000, 1, 0, 0, 1, 0);
    tbl[1]  = mk(0, OP_SUB, 64'd5,         64'd5,         0, 0, 64'h0,         0, 1, 1, 0, 0);
    tbl[2]  = mk(0, OP_SUB, 64'd3,         64'd5,         0, 0, 64'hFFFF_FFFE, 1, 0, 0, 0, 0);
    tbl[3]  = mk(0, OP_RSB, 64'd3,         64'd5,         0, 0, 64'h2,         0, 0, 1, 0, 0);
    tbl[4]  = mk(0, OP_SBC, 64'd5,         64'd3,         0, 0, 64'h1,         0, 0, 1, 0, 0);
    tbl[5]  = mk(0, OP_AND, 64'hF0F0,      64'h0FF0,      1, 1, 64'h00F0,      0, 0, 1, 1, 0);
    tbl[6]  = mk(0, 4'h7,   64'h1234,      64'h5678,      0, 1, 64'h0,         0, 1, 0, 1, 1);
    tbl[7]  = mk(0, OP_ORR, 64'hF0F0,      64'h0FF0,      0, 0, 64'hFFF0,      0, 0, 0, 0, 0);
    tbl[8]  = mk(0, OP_EOR, 64'hF0F0,      64'h0FF0,      0, 0, 64'hFF00,      0, 0, 0, 0, 0);
    tbl[9]  = mk(0, OP_BIC, 64'hF0F0,      64'h0FF0,      0, 0, 64'hF000,      0, 0, 0, 0, 0);
    tbl[10] = mk(0, OP_MVN, 64'h1234,      64'h0,         1, 0, 64'hFFFF_FFFF, 1, 0, 1, 0, 0);
    tbl[11] = mk(0, OP_OP1, 64'h0,         64'd5,         0, 1, 64'h0,         0, 1, 0, 1, 0);
    tbl[12] = mk(0, OP_OP2, 64'd5,         64'h8000_0000, 0, 0, 64'h8000_0000, 1, 0, 0, 0, 0);
    tbl[13] = mk(0, OP_ADC, 64'hFFFF_FFFF, 64'h0,         1, 0, 64'h0,         0, 1, 1, 0, 0);
    tbl[14] = mk(0, OP_RSC, 64'd5,         64'd3,         1, 0, 64'hFFFF_FFFE, 1, 0, 0, 0, 0);
    tbl[15] = mk(0, OP_SUB, 64'h8000_0000, 64'h1,         0, 0, 64'h7FFF_FFFF, 0, 0, 1, 1, 0);
    tbl[16] = mk(0, 4'hF,   64'h55,        64'h66,        1, 0, 64'h0,         0, 1, 1, 0, 1);
    tbl[17] = mk(2, OP_ADC, 64'hFF,        64'h00,        1, 0, 64'h00,        0, 1, 1, 0, 0);
    tbl[18] = mk(2, OP_ADD, 64'h7F,        64'h01,        0, 0, 64'h80,        1, 0, 0, 1, 0);

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int d = 0; d < 3; d++) begin
      chk_bit($sformatf("dut%0d_reset_out_valid", d), out_valid[d], 1'b0);
      chk_vec($sformatf("dut%0d_reset_outputs", d), dut_vec(d), 69'd0);
      chk_bit($sformatf("dut%0d_reset_in_ready", d), in_ready[d], 1'b1);
    end

    run_table();
    stream_test();
    flush_test();
    reset_test();
    run_random(0, 60, 32);
    run_random(1, 60, 32);
    run_random(2, 60, 8);

    for (int d = 0; d < 3; d++) begin
      n_checks++;
      if (q_size(d) != 0) begin
        n_fail++;
        $display("FAIL dut%0d_queue_drained: got %0d pending, required 0", d, q_size(d));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
